// File: rtl/uiuart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-entry hold register lets the next byte start right after the current stop bit(s).
module uiuart_tx #(
   parameter int unsigned BAUD_DIV   = 10416,  // bit period minus 1, in I_clk cycles
   parameter int unsigned PARITY_EN  = 0,      // 1 = parity bit after D7
   parameter int unsigned PARITY_ODD = 0,      // 1 = odd parity, 0 = even
   parameter int unsigned STOP_BITS  = 1       // 1 or 2
) (
   input  logic       I_clk,
   input  logic       I_uart_rstn,
   input  logic [7:0] I_uart_wdata,
   input  logic       I_uart_wvalid,
   output logic       O_uart_wready,
   output logic       O_uart_tx,
   output logic       O_uart_busy
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   localparam logic [15:0] BaudMax  = 16'(BAUD_DIV);
   localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);
   localparam logic        ParOdd   = (PARITY_ODD != 0);
   localparam logic        ParEn    = (PARITY_EN != 0);

   state_e      state_q, state_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic [7:0]  shift_q, shift_d;
   logic        parity_q, parity_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        tx_q, tx_d;

   logic accept;
   logic bit_end;

   // Handshake and status outputs
   always_comb begin
      O_uart_wready = I_uart_rstn & ~hold_full_q;
      O_uart_busy   = (state_q != StIdle) | hold_full_q;
      O_uart_tx     = tx_q;
      accept        = I_uart_wvalid & O_uart_wready;
      bit_end       = (baud_cnt_q == BaudMax);
   end

   // Next-state logic: hold register capture, frame sequencing and line value
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      baud_cnt_d  = baud_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      tx_d        = tx_q;

      // Accept needs an empty hold and a drain needs a full one, so the two never collide.
      if (accept) begin
         hold_d      = I_uart_wdata;
         hold_full_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            tx_d       = 1'b1;
            baud_cnt_d = 16'd0;
            bit_cnt_d  = 3'd0;
            if (hold_full_q) begin
               state_d     = StStart;
               shift_d     = hold_q;
               parity_d    = (^hold_q) ^ ParOdd;
               hold_full_d = 1'b0;
               tx_d        = 1'b0;
            end
         end

         StStart: begin
            if (bit_end) begin
               baud_cnt_d = 16'd0;
               bit_cnt_d  = 3'd0;
               state_d    = StData;
               tx_d       = shift_q[0];
               shift_d    = {1'b0, shift_q[7:1]};
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         StData: begin
            if (bit_end) begin
               baud_cnt_d = 16'd0;
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
                  if (ParEn) begin
                     state_d = StParity;
                     tx_d    = parity_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         StParity: begin
            if (bit_end) begin
               baud_cnt_d = 16'd0;
               bit_cnt_d  = 3'd0;
               state_d    = StStop;
               tx_d       = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         StStop: begin
            tx_d = 1'b1;
            if (bit_end) begin
               baud_cnt_d = 16'd0;
               if (bit_cnt_q == StopLast) begin
                  bit_cnt_d = 3'd0;
                  // Reload straight from hold on the same edge so frames abut with no idle gap.
                  if (hold_full_q) begin
                     state_d     = StStart;
                     shift_d     = hold_q;
                     parity_d    = (^hold_q) ^ ParOdd;
                     hold_full_d = 1'b0;
                     tx_d        = 1'b0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State registers; the line is forced high asynchronously while in reset
   always_ff @(posedge I_clk or negedge I_uart_rstn) begin
      if (!I_uart_rstn) begin
         state_q     <= StIdle;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         baud_cnt_q  <= 16'd0;
         bit_cnt_q   <= 3'd0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_q        <= tx_d;
      end
   end

endmodule
